irq_controller: RTL

Parametrised multi-channel interrupt request controller that replaces the single random interrupt line driven at the core's interrupt input. It latches NUM_IRQ request sources (per-channel edge or level mode), applies a mask, and selects one request by fixed priority. It presents that request to the core as interrupt plus irq_id, gated on ps_idle when IDLE_ONLY=1. A request is retired by an ack handshake, followed by a programmable holdoff before the next request.

---
 rtl/irq_pkg.sv | 30 +++
 rtl/irq_controller_if.sv | 24 ++
 rtl/irq_pending_latch.sv | 35 +++
 rtl/irq_controller.sv | 111 +++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and the
// fixed-priority (lowest index wins) encoder.
package irq_pkg;

    localparam int MAX_IRQ = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_t;

    typedef struct packed {
        logic       any;
        logic [3:0] idx;
    } prio_t;

    // Scan from the top down so the lowest set index is the last one written.
    function automatic prio_t prio_enc(input logic [MAX_IRQ-1:0] vec);
        prio_t res;
        res.any = 1'b0;
        res.idx = 4'd0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            res.idx = vec[i] ? 4'(i) : res.idx;
            res.any = res.any | vec[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Core-facing interrupt handshake: request/id towards the core, ack and
// sequencer-idle flag back from it.
interface irq_controller_if #(
    parameter int ID_WIDTH = 2
);
    logic                interrupt;
    logic [ID_WIDTH-1:0] irq_id;
    logic                irq_ack;
    logic                ps_idle;

    modport master (
        output interrupt,
        output irq_id,
        input  irq_ack,
        input  ps_idle
    );

    modport slave (
        input  interrupt,
        input  irq_id,
        output irq_ack,
        output ps_idle
    );
endinterface

// File: rtl/irq_pending_latch.sv
// One request channel: rising-edge or level capture of the source into a
// pending bit that the controller clears when it retires this channel.
module irq_pending_latch (
    input  logic clk,
    input  logic reset,
    input  logic src,
    input  logic edge_mode,
    input  logic clr,
    output logic pending
);

    logic src_prev_r;

    // Edge detect and pending bit; a new edge beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_prev_r <= 1'b0;
            pending    <= 1'b0;
        end else begin
            src_prev_r <= src;
            if (edge_mode) begin
                if (src && !src_prev_r) begin
                    pending <= 1'b1;
                end else if (clr) begin
                    pending <= 1'b0;
                end else begin
                    pending <= pending;
                end
            end else begin
                pending <= src;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Multi-channel interrupt controller: per-channel pending latches, masking,
// fixed priority, and a request/ack/holdoff sequencer towards the core.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_IRQ       = 4,
    parameter int ID_WIDTH      = 2,
    parameter int HOLDOFF_WIDTH = 3,
    parameter int IDLE_ONLY     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IRQ-1:0]       irq_src,
    input  logic [NUM_IRQ-1:0]       edge_mode,
    input  logic [NUM_IRQ-1:0]       irq_mask,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff,
    irq_controller_if.master         core,
    output logic [NUM_IRQ-1:0]       irq_pending,
    output logic                     busy
);

    irq_state_t               state_r;
    logic                     interrupt_r;
    logic [ID_WIDTH-1:0]      irq_id_r;
    logic [HOLDOFF_WIDTH-1:0] cnt_r;
    logic                     busy_r;

    logic [NUM_IRQ-1:0]       pend_s;
    logic [NUM_IRQ-1:0]       clr_s;
    logic [MAX_IRQ-1:0]       vec_s;
    logic                     ack_s;
    logic                     gate_s;
    prio_t                    prio_s;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_latch
        irq_pending_latch u_latch (
            .clk       (clk),
            .reset     (reset),
            .src       (irq_src[i]),
            .edge_mode (edge_mode[i]),
            .clr       (clr_s[i]),
            .pending   (pend_s[i])
        );
    end

    assign ack_s  = (state_r == REQ) && core.irq_ack;
    assign gate_s = (IDLE_ONLY == 0) ? 1'b1 : core.ps_idle;
    assign prio_s = prio_enc(vec_s);

    // Masked request vector widened to the encoder width, plus per-channel retire strobes.
    always_comb begin
        vec_s = '0;
        clr_s = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            vec_s[i] = pend_s[i] & irq_mask[i];
            clr_s[i] = ack_s && (irq_id_r == ID_WIDTH'(i));
        end
    end

    // Request sequencer with holdoff counter and registered core-facing outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            interrupt_r <= 1'b0;
            irq_id_r    <= '0;
            cnt_r       <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (prio_s.any && gate_s) begin
                        state_r     <= REQ;
                        interrupt_r <= 1'b1;
                        irq_id_r    <= ID_WIDTH'(prio_s.idx);
                        busy_r      <= 1'b1;
                    end
                end
                REQ: begin
                    if (core.irq_ack) begin
                        state_r     <= HOLDOFF;
                        interrupt_r <= 1'b0;
                        cnt_r       <= holdoff;
                    end
                end
                HOLDOFF: begin
                    // Exit on 0 or 1 so a zero holdoff still spends one cycle here.
                    if (cnt_r <= HOLDOFF_WIDTH'(1)) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - HOLDOFF_WIDTH'(1);
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    interrupt_r <= 1'b0;
                    irq_id_r    <= '0;
                    cnt_r       <= '0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign core.interrupt = interrupt_r;
    assign core.irq_id    = irq_id_r;
    assign irq_pending    = pend_s;
    assign busy           = busy_r;

endmodule
